hmmm_boot_mem: RTL



---
 rtl/hmmm_boot_mem.sv | 137 +++++++++++++
 1 files changed

// File: rtl/hmmm_boot_mem.sv
// hmmm_boot_mem: 256 x 15-bit unified HMMM memory with a byte-stream boot loader
// that holds the core in reset until the image is loaded.
`default_nettype none

module hmmm_boot_mem #(
  parameter int DEPTH          = 256,
  parameter int RELEASE_CYCLES = 2
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     ld_valid,
  output logic                     ld_ready,
  input  logic [7:0]               ld_data,
  input  logic                     ld_last,
  output logic                     cpu_reset,
  input  logic [$clog2(DEPTH)-1:0] cpu_adr,
  input  logic                     cpu_memwrite,
  input  logic [7:0]               cpu_wdata,
  output logic [14:0]              cpu_rdata,
  output logic                     done,
  output logic                     load_err,
  output logic [$clog2(DEPTH):0]   ld_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int RW = $clog2(RELEASE_CYCLES + 1);

  typedef enum logic [1:0] {
    LOAD_HI = 2'd0,
    LOAD_LO = 2'd1,
    RELEASE = 2'd2,
    RUN     = 2'd3
  } state_e;

  state_e          state_q, state_d;
  logic [6:0]      hi_q, hi_d;
  logic [AW-1:0]   ptr_q, ptr_d;
  logic [AW:0]     cnt_q, cnt_d;
  logic            err_q, err_d;
  logic [RW-1:0]   rel_q, rel_d;

  logic            mem_we;
  logic [AW-1:0]   mem_waddr;
  logic [14:0]     mem_wdata;
  logic [14:0]     mem [DEPTH];

  always_comb begin
    state_d   = state_q;
    hi_d      = hi_q;
    ptr_d     = ptr_q;
    cnt_d     = cnt_q;
    err_d     = err_q;
    rel_d     = rel_q;
    mem_we    = 1'b0;
    mem_waddr = ptr_q;
    mem_wdata = {hi_q, ld_data};
    case (state_q)
      LOAD_HI: begin
        if (ld_valid) begin
          // A final marker on a high byte leaves half a word: drop it and flag.
          if (ld_last) begin
            err_d   = 1'b1;
            state_d = RELEASE;
          end else begin
            hi_d    = ld_data[6:0];
            state_d = LOAD_LO;
          end
        end
      end
      LOAD_LO: begin
        if (ld_valid) begin
          mem_we = 1'b1;
          ptr_d  = ptr_q + 1'b1;
          cnt_d  = cnt_q + 1'b1;
          if (ld_last) begin
            state_d = RELEASE;
          end else if (ptr_q == AW'(DEPTH - 1)) begin
            err_d   = 1'b1;
            state_d = RELEASE;
          end else begin
            state_d = LOAD_HI;
          end
        end
      end
      RELEASE: begin
        if (rel_q == RW'(RELEASE_CYCLES - 1)) begin
          state_d = RUN;
        end else begin
          rel_d = rel_q + 1'b1;
        end
      end
      RUN: begin
        if (cpu_memwrite) begin
          mem_we    = 1'b1;
          mem_waddr = cpu_adr;
          mem_wdata = {7'b0, cpu_wdata};
        end
      end
      default: state_d = LOAD_HI;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= LOAD_HI;
      hi_q    <= '0;
      ptr_q   <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
      rel_q   <= '0;
    end else begin
      state_q <= state_d;
      hi_q    <= hi_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      rel_q   <= rel_d;
    end
  end

  // Contents survive reset; only the write itself is suppressed during it.
  always_ff @(posedge clk) begin
    if (mem_we && !reset) begin
      mem[mem_waddr] <= mem_wdata;
    end
  end

  assign ld_ready  = (state_q == LOAD_HI) || (state_q == LOAD_LO);
  assign cpu_reset = (state_q != RUN);
  assign done      = (state_q == RUN);
  assign load_err  = err_q;
  assign ld_count  = cnt_q;
  assign cpu_rdata = (state_q == RUN) ? mem[cpu_adr] : 15'h0;

endmodule

`default_nettype wire
